// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver with PicoBlaze read ports.
// It synchronises and glitch-filters ps2c, assembles 11-bit frames and
// strips the E0 (extended) and F0 (break) prefixes. The last make code is
// held in a one-entry register for firmware to read.
// Optional build macro: KBD_EXT_TAG_EN. When it is defined, the extended
// flag is latched alongside each loaded code and reported in status bit 6.
module ps2_kbd_rx #(
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT     = 200000,
    parameter logic [7:0] KBD_DATA_ID = 8'h0b,
    parameter logic [7:0] KBD_STAT_ID = 8'h0c
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic [7:0] port_ID,
    input  logic       rd_strobe,
    output logic [7:0] in_port,
    output logic       interrupt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

    logic          ps2c_s1_q, ps2c_s1_d, ps2c_s2_q, ps2c_s2_d;
    logic          ps2d_s1_q, ps2d_s1_d, ps2d_s2_q, ps2d_s2_d;
    logic          filt_q, filt_d, armed_q, armed_d, fall_q, fall_d;
    logic [4:0]    fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    code_q, code_d;
    logic          key_ready_q, key_ready_d;
    logic          overrun_q, overrun_d;
    logic          perr_q, perr_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          data_rd, stat_rd, frame_ok, ext_tag;
`ifdef KBD_EXT_TAG_EN
    logic          ext_reg_q, ext_reg_d;
    assign ext_tag = ext_reg_q;
`else
    assign ext_tag = 1'b0;
`endif

    // Two-flop synchronisers for the asynchronous PS/2 lines
    always_comb begin
        ps2c_s1_d = ps2c;
        ps2c_s2_d = ps2c_s1_q;
        ps2d_s1_d = ps2d;
        ps2d_s2_d = ps2d_s1_q;
    end

    // Glitch filter; a fall is only reported once the filter has seen the
    // line high, so a ps2c held low across reset cannot fake a start bit
    always_comb begin
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        armed_d = armed_q;
        fall_d  = 1'b0;
        if (ps2c_s2_q == filt_q) begin
            fcnt_d = 5'd0;
        end else if (fcnt_q == 5'(FILTER_LEN - 1)) begin
            filt_d = ps2c_s2_q;
            fcnt_d = 5'd0;
            fall_d = filt_q & armed_q;
        end else begin
            fcnt_d = fcnt_q + 5'd1;
        end
        if (filt_q && ps2c_s2_q) begin
            armed_d = 1'b1;
        end
    end

    // Frame FSM, prefix stripping and the firmware-visible registers
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        code_d      = code_q;
        key_ready_d = key_ready_q;
        overrun_d   = overrun_q;
        perr_d      = perr_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
`ifdef KBD_EXT_TAG_EN
        ext_reg_d   = ext_reg_q;
`endif
        data_rd  = rd_strobe && (port_ID == KBD_DATA_ID);
        stat_rd  = rd_strobe && (port_ID == KBD_STAT_ID);
        frame_ok = shift_q[9] && (^shift_q[8:0]);
        if (data_rd) begin
            key_ready_d = 1'b0;
        end
        if (stat_rd) begin
            overrun_d = 1'b0;
            perr_d    = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (fall_q && !ps2d_s2_q) begin
                    state_d  = RX;
                    bitcnt_d = 4'd10;
                    to_cnt_d = '0;
                end
            end
            RX: begin
                if (fall_q) begin
                    shift_d  = {ps2d_s2_q, shift_q[9:1]};
                    bitcnt_d = bitcnt_q - 4'd1;
                    to_cnt_d = '0;
                    if (bitcnt_q == 4'd1) begin
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!frame_ok) begin
                    perr_d = 1'b1;
                end else if (shift_q[7:0] == 8'he0) begin
                    ext_d = 1'b1;
                end else if (shift_q[7:0] == 8'hf0) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else begin
                    ext_d = 1'b0;
                    if (!key_ready_q || data_rd) begin
                        code_d      = shift_q[7:0];
                        key_ready_d = 1'b1;
`ifdef KBD_EXT_TAG_EN
                        ext_reg_d   = ext_q;
`endif
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1_q   <= 1'b0;
            ps2c_s2_q   <= 1'b0;
            ps2d_s1_q   <= 1'b0;
            ps2d_s2_q   <= 1'b0;
            filt_q      <= 1'b1;
            fcnt_q      <= 5'd0;
            armed_q     <= 1'b0;
            fall_q      <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 10'd0;
            to_cnt_q    <= '0;
            code_q      <= 8'h00;
            key_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
            perr_q      <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
`ifdef KBD_EXT_TAG_EN
            ext_reg_q   <= 1'b0;
`endif
        end else begin
            ps2c_s1_q   <= ps2c_s1_d;
            ps2c_s2_q   <= ps2c_s2_d;
            ps2d_s1_q   <= ps2d_s1_d;
            ps2d_s2_q   <= ps2d_s2_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            armed_q     <= armed_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            code_q      <= code_d;
            key_ready_q <= key_ready_d;
            overrun_q   <= overrun_d;
            perr_q      <= perr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
`ifdef KBD_EXT_TAG_EN
            ext_reg_q   <= ext_reg_d;
`endif
        end
    end

    // Read-data mux towards the PicoBlaze
    always_comb begin
        in_port = 8'h00;
        if (port_ID == KBD_DATA_ID) begin
            in_port = code_q;
        end else if (port_ID == KBD_STAT_ID) begin
            in_port = {overrun_q, ext_tag, 4'b0000, perr_q, key_ready_q};
        end
    end

    assign interrupt = key_ready_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: a table of frames with expected
// status/code values, plus hand-written sequences for latency, a load that
// coincides with a data read, the timeout, ps2c glitches and reset mid-frame.
module tb_ps2_kbd_rx;

    localparam int HALF = 20;
    localparam int ACT_NONE = 0;
    localparam int ACT_RDD  = 1;
    localparam int ACT_RDS  = 2;
`ifdef KBD_EXT_TAG_EN
    localparam logic [7:0] ET = 8'h40;
`else
    localparam logic [7:0] ET = 8'h00;
`endif

    logic       clk, reset, ps2c, ps2d, rd_strobe, interrupt;
    logic [7:0] port_ID, in_port;
    int         checks, errors;

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic       exp_irq;
        logic [7:0] exp_stat;
        logic [7:0] exp_data;
        int         act;
        logic [7:0] exp_after;
    } vec_t;

    vec_t vecs[10];

    ps2_kbd_rx #(
        .FILTER_LEN(8), .TIMEOUT(1000), .KBD_DATA_ID(8'h0b), .KBD_STAT_ID(8'h0c)
    ) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .port_ID(port_ID),
        .rd_strobe(rd_strobe), .in_port(in_port), .interrupt(interrupt)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every mismatch prints a FAIL line
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] d, input bit bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ps2d = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2c = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 ps2c = 1'b1;
        end
    endtask

    // Sends ten bits, then sets up the stop bit and drops ps2c just after an edge
    task automatic stopFall(input logic [7:0] d);
        sendBits(frameBits(d, 1'b0), 10);
        @(posedge clk); #1 ps2d = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit bad);
        sendBits(frameBits(d, bad), 11);
        repeat (30) @(posedge clk);
    endtask

    task automatic peek(input logic [7:0] addr, output logic [7:0] val);
        @(negedge clk);
        port_ID = addr;
        #1 val = in_port;
    endtask

    task automatic readPort(input logic [7:0] addr, output logic [7:0] val);
        @(negedge clk);
        port_ID   = addr;
        rd_strobe = 1'b1;
        #1 val = in_port;
        @(posedge clk);
        #1 rd_strobe = 1'b0;
        port_ID = 8'h00;
    endtask

    task automatic doReset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int lat;
        checks = 0; errors = 0;
        ps2c = 1'b1; ps2d = 1'b1; port_ID = 8'h00; rd_strobe = 1'b0; reset = 1'b0;

        vecs[0] = '{8'h75, 1'b0, 1'b1, 8'h01,      8'h75, ACT_RDD,  8'h00};
        vecs[1] = '{8'he0, 1'b0, 1'b0, 8'h00,      8'h00, ACT_NONE, 8'h00};
        vecs[2] = '{8'hf0, 1'b0, 1'b0, 8'h00,      8'h00, ACT_NONE, 8'h00};
        vecs[3] = '{8'h75, 1'b0, 1'b0, 8'h00,      8'h00, ACT_NONE, 8'h00};
        vecs[4] = '{8'he0, 1'b0, 1'b0, 8'h00,      8'h00, ACT_NONE, 8'h00};
        vecs[5] = '{8'h75, 1'b0, 1'b1, 8'h01 | ET, 8'h75, ACT_RDD,  ET};
        vecs[6] = '{8'h05, 1'b1, 1'b0, 8'h02 | ET, 8'h00, ACT_RDS,  ET};
        vecs[7] = '{8'h05, 1'b0, 1'b1, 8'h01,      8'h05, ACT_NONE, 8'h00};
        vecs[8] = '{8'h06, 1'b0, 1'b1, 8'h81,      8'h05, ACT_RDD,  8'h80};
        vecs[9] = '{8'h06, 1'b0, 1'b1, 8'h81,      8'h06, ACT_RDS,  8'h01};

        doReset();
        repeat (5) @(posedge clk);
        peek(8'h0b, v); checkOutput("reset_data", v, 8'h00);
        peek(8'h0c, v); checkOutput("reset_stat", v, 8'h00);
        checkOutput("reset_irq", {7'd0, interrupt}, 8'h00);

        // Latency from the stop-bit fall on the pin to key_ready
        stopFall(8'h75);
        lat = 0;
        while (interrupt !== 1'b1 && lat < 100) begin
            @(posedge clk); #1 lat++;
        end
        checkOutput("latency_ok", {7'd0, (lat >= 11 && lat <= 13)}, 8'h01);
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b1;
        readPort(8'h0b, v); checkOutput("lat_read", v, 8'h75);
        peek(8'h0c, v); checkOutput("lat_cleared", v, 8'h00);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].code, vecs[i].bad);
            checkOutput($sformatf("v%0d_irq", i), {7'd0, interrupt}, {7'd0, vecs[i].exp_irq});
            peek(8'h0c, v); checkOutput($sformatf("v%0d_stat", i), v, vecs[i].exp_stat);
            if (vecs[i].exp_irq) begin
                peek(8'h0b, v); checkOutput($sformatf("v%0d_code", i), v, vecs[i].exp_data);
            end
            if (vecs[i].act == ACT_RDD) begin
                readPort(8'h0b, v); checkOutput($sformatf("v%0d_rdd", i), v, vecs[i].exp_data);
            end else if (vecs[i].act == ACT_RDS) begin
                readPort(8'h0c, v); checkOutput($sformatf("v%0d_rds", i), v, vecs[i].exp_stat);
            end
            if (vecs[i].act != ACT_NONE) begin
                peek(8'h0c, v); checkOutput($sformatf("v%0d_after", i), v, vecs[i].exp_after);
            end
        end

        // Code 0x0c completes in the same cycle as a data read of 0x06
        peek(8'h0a, v); checkOutput("other_port", v, 8'h00);
        stopFall(8'h0c);
        if (lat > 1) repeat (lat - 1) @(posedge clk);
        #1 port_ID = 8'h0b; rd_strobe = 1'b1;
        @(posedge clk);
        #1 rd_strobe = 1'b0; port_ID = 8'h00;
        checkOutput("simul_irq", {7'd0, interrupt}, 8'h01);
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b1;
        peek(8'h0c, v); checkOutput("simul_stat", v, 8'h01);
        peek(8'h0b, v); checkOutput("simul_code", v, 8'h0c);
        readPort(8'h0b, v);

        // Partial frame followed by a long idle ps2c
        sendBits(frameBits(8'h72, 1'b0), 5);
        repeat (1500) @(posedge clk);
        peek(8'h0c, v); checkOutput("timeout_stat", v, 8'h00);
        applyStimulus(8'h72, 1'b0);
        peek(8'h0c, v); checkOutput("after_to_stat", v, 8'h01);
        peek(8'h0b, v); checkOutput("after_to_code", v, 8'h72);
        readPort(8'h0b, v);

        // Short low glitches on ps2c with data low must not start a frame
        ps2d = 1'b0;
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1 ps2c = 1'b0;
            repeat (3) @(posedge clk);
            #1 ps2c = 1'b1;
            repeat (10) @(posedge clk);
        end
        repeat (50) @(posedge clk);
        peek(8'h0c, v); checkOutput("glitch_stat", v, 8'h00);
        applyStimulus(8'h29, 1'b0);
        peek(8'h0c, v); checkOutput("glitch_next_stat", v, 8'h01);
        peek(8'h0b, v); checkOutput("glitch_next_code", v, 8'h29);

        // Reset mid-frame with ps2c held low through and after reset
        sendBits(frameBits(8'h33, 1'b0), 4);
        @(posedge clk); #1 ps2d = 1'b0; ps2c = 1'b0;
        repeat (HALF) @(posedge clk);
        doReset();
        repeat (2) @(posedge clk);
        checkOutput("rst_irq", {7'd0, interrupt}, 8'h00);
        peek(8'h0c, v); checkOutput("rst_stat", v, 8'h00);
        peek(8'h0b, v); checkOutput("rst_data", v, 8'h00);
        repeat (40) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (HALF) @(posedge clk);
        applyStimulus(8'h6b, 1'b0);
        peek(8'h0c, v); checkOutput("post_rst_stat", v, 8'h01);
        peek(8'h0b, v); checkOutput("post_rst_code", v, 8'h6b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
